// File: rtl/arcade_button_conditioner_if.sv
// Control bus between the input mapper and the button conditioner:
// raw active-high controls in, conditioned active-low buttons and status out.
interface arcade_button_conditioner_if;
    logic [7:0] raw_in;
    logic [7:0] button_n;
    logic       coin_busy;
    logic       tick;

    modport master (
        output raw_in,
        input  button_n,
        input  coin_busy,
        input  tick
    );

    modport slave (
        input  raw_in,
        output button_n,
        output coin_busy,
        output tick
    );
endinterface

// File: rtl/arcade_button_conditioner.sv
// Synchronises, debounces and coin-shapes the 8 arcade controls feeding the core's active-low button_in.
// Optional macro BUTTON_SOCD_EN cancels opposing directions (up/down, left/right) after debounce.
module arcade_button_conditioner #(
    parameter int PRESCALE         = 6000,
    parameter int DEBOUNCE_TICKS   = 8,
    parameter int COIN_PULSE_TICKS = 20,
    parameter int COIN_GAP_TICKS   = 40,
    parameter int COIN_BIT         = 5
) (
    input  logic                        clk_sys,
    input  logic                        res_n,
    arcade_button_conditioner_if.slave  bus
);

    localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DB_W   = $clog2(DEBOUNCE_TICKS + 1);
    localparam int TM_MAX = (COIN_PULSE_TICKS > COIN_GAP_TICKS) ? COIN_PULSE_TICKS : COIN_GAP_TICKS;
    localparam int TM_W   = $clog2(TM_MAX + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        GAP      = 2'd2,
        WAIT_REL = 2'd3
    } coin_state_t;

    logic [PS_W-1:0] pcnt, pcnt_nxt;
    logic            tick_q;

    logic [7:0]      s1, sync;
    logic [7:0]      st, st_nxt;
    logic [DB_W-1:0] cnt     [8];
    logic [DB_W-1:0] cnt_nxt [8];

    coin_state_t     state, state_nxt;
    logic [TM_W-1:0] timer, timer_nxt;
    logic            coin_rise;

    logic [7:0]      cond;
    logic [7:0]      button_q;
    logic            busy_q;

    // tick is registered from the next count so it is low in reset and
    // still coincides with the cycle where the counter sits at PRESCALE-1
    always_comb begin
        pcnt_nxt = (pcnt == PS_W'(PRESCALE - 1)) ? '0 : pcnt + 1'b1;
    end

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            pcnt   <= '0;
            tick_q <= 1'b0;
        end else begin
            pcnt   <= pcnt_nxt;
            tick_q <= (pcnt_nxt == PS_W'(PRESCALE - 1));
        end
    end

    always_comb begin
        st_nxt = st;
        for (int unsigned i = 0; i < 8; i++) begin
            cnt_nxt[i] = cnt[i];
            if (tick_q) begin
                if (sync[i] == st[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt[i] == DB_W'(DEBOUNCE_TICKS - 1)) begin
                    st_nxt[i]  = sync[i];
                    cnt_nxt[i] = '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            s1   <= '0;
            sync <= '0;
            st   <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1   <= bus.raw_in;
            sync <= s1;
            st   <= st_nxt;
            for (int unsigned i = 0; i < 8; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Coin FSM looks at the debounced state as it is about to be written,
    // so state and st change on the same edge
    assign coin_rise = tick_q & st_nxt[COIN_BIT] & ~st[COIN_BIT];

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            IDLE: begin
                if (coin_rise) begin
                    state_nxt = PULSE;
                    timer_nxt = TM_W'(COIN_PULSE_TICKS - 1);
                end
            end
            PULSE: begin
                if (tick_q) begin
                    if (timer == '0) begin
                        state_nxt = GAP;
                        timer_nxt = TM_W'(COIN_GAP_TICKS - 1);
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
            end
            GAP: begin
                if (tick_q) begin
                    if (timer == '0) begin
                        state_nxt = st_nxt[COIN_BIT] ? WAIT_REL : IDLE;
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
            end
            WAIT_REL: begin
                if (!st_nxt[COIN_BIT]) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        cond           = st;
        cond[COIN_BIT] = (state == PULSE);
`ifdef BUTTON_SOCD_EN
        if (cond[0] && cond[1]) begin
            cond[0] = 1'b0;
            cond[1] = 1'b0;
        end
        if (cond[2] && cond[3]) begin
            cond[2] = 1'b0;
            cond[3] = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            button_q <= '1;
            busy_q   <= 1'b0;
        end else begin
            button_q <= ~cond;
            busy_q   <= (state != IDLE);
        end
    end

    assign bus.button_n  = button_q;
    assign bus.coin_busy = busy_q;
    assign bus.tick      = tick_q;

endmodule

// File: tb/tb_arcade_button_conditioner.sv
// Directed bench for arcade_button_conditioner with PRESCALE=4, DEBOUNCE=3, PULSE=5, GAP=2.
// Edge numbers count rising edges after reset release; debounce acts on edges 4, 8, 12, ...
module tb_arcade_button_conditioner;

    logic clk_sys = 1'b0;
    logic res_n   = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   edge_n   = 0;
    int   low_cnt  = 0;
    int   snap     = 0;

    arcade_button_conditioner_if bus ();

    arcade_button_conditioner #(
        .PRESCALE         (4),
        .DEBOUNCE_TICKS   (3),
        .COIN_PULSE_TICKS (5),
        .COIN_GAP_TICKS   (2),
        .COIN_BIT         (5)
    ) dut (
        .clk_sys (clk_sys),
        .res_n   (res_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // Cycles during which the conditioned coin output is asserted
    always @(negedge clk_sys) begin
        if (bus.button_n[5] === 1'b0) low_cnt++;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step_to(input int n);
        while (edge_n < n) begin
            @(posedge clk_sys);
            #1;
            edge_n++;
        end
    endtask

    initial begin
        bus.raw_in = 8'hFF;
        repeat (3) @(posedge clk_sys);
        #1;
        check("reset_button_n", bus.button_n, 8'hFF);
        check("reset_coin_busy", {7'd0, bus.coin_busy}, 8'h00);
        check("reset_tick", {7'd0, bus.tick}, 8'h00);
        res_n      = 1'b1;
        bus.raw_in = 8'h00;
        edge_n     = 0;

        for (int k = 1; k <= 8; k++) begin
            step_to(k);
            check($sformatf("tick_edge%0d", k), {7'd0, bus.tick}, ((k % 4) == 3) ? 8'h01 : 8'h00);
        end

        // Clean press on bit 0: sync high from edge 10, ticks at 12, 16, 20
        bus.raw_in = 8'h01;
        step_to(20);
        check("press0_before", bus.button_n, 8'hFF);
        step_to(21);
        check("press0_after", bus.button_n, 8'hFE);

        // Bounce on bit 1: two ticks high, one low, then three high
        bus.raw_in = 8'h03;
        step_to(28);
        bus.raw_in = 8'h01;
        step_to(32);
        bus.raw_in = 8'h03;
        step_to(33);
        check("bounce_no_early", bus.button_n, 8'hFE);
        step_to(44);
        check("bounce_before", bus.button_n, 8'hFE);
        step_to(45);
        check("bounce_after", bus.button_n, 8'hFC);
        bus.raw_in = 8'h00;
        step_to(57);
        check("release01", bus.button_n, 8'hFF);

        // Coin held 40 ticks: debounced at 68, pulse visible edges 69..88
        bus.raw_in = 8'h20;
        snap       = low_cnt;
        step_to(68);
        check("coin_pre_out", bus.button_n, 8'hFF);
        check("coin_pre_busy", {7'd0, bus.coin_busy}, 8'h00);
        step_to(69);
        check("coin_pulse_start", bus.button_n, 8'hDF);
        check("coin_busy_pulse", {7'd0, bus.coin_busy}, 8'h01);
        step_to(88);
        check("coin_pulse_end", bus.button_n, 8'hDF);
        step_to(89);
        check("coin_after_pulse", bus.button_n, 8'hFF);
        check("coin_busy_gap", {7'd0, bus.coin_busy}, 8'h01);
        step_to(100);
        check("coin_wait_rel_out", bus.button_n, 8'hFF);
        check("coin_busy_wait", {7'd0, bus.coin_busy}, 8'h01);
        step_to(217);
        bus.raw_in = 8'h00;
        step_to(228);
        check("coin_busy_held", {7'd0, bus.coin_busy}, 8'h01);
        step_to(229);
        check("coin_busy_drop", {7'd0, bus.coin_busy}, 8'h00);
        check("coin_one_pulse", 8'(low_cnt - snap), 8'd20);

        // Press, quick release, re-press debounced at 264 while in GAP
        snap       = low_cnt;
        bus.raw_in = 8'h20;
        step_to(240);
        bus.raw_in = 8'h00;
        step_to(252);
        bus.raw_in = 8'h20;
        step_to(241);
        step_to(268);
        bus.raw_in = 8'h00;
        step_to(280);
        check("gap_busy_held", {7'd0, bus.coin_busy}, 8'h01);
        step_to(281);
        check("gap_busy_drop", {7'd0, bus.coin_busy}, 8'h00);
        check("gap_press_dropped", 8'(low_cnt - snap), 8'd20);

        // Fresh press from IDLE: debounced at 292, pulse edges 293..312
        snap       = low_cnt;
        bus.raw_in = 8'h20;
        step_to(292);
        check("repress_pre", bus.button_n, 8'hFF);
        step_to(293);
        check("repress_pulse", bus.button_n, 8'hDF);
        step_to(313);
        check("repress_end", bus.button_n, 8'hFF);
        check("repress_width", 8'(low_cnt - snap), 8'd20);

        // Up+down together, coin released at the same time
        bus.raw_in = 8'h03;
        step_to(325);
`ifdef BUTTON_SOCD_EN
        check("updown_both", bus.button_n, 8'hFF);
`else
        check("updown_both", bus.button_n, 8'hFC);
`endif
        check("updown_busy", {7'd0, bus.coin_busy}, 8'h00);
        bus.raw_in = 8'h01;
        step_to(337);
        check("up_only", bus.button_n, 8'hFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
